// File: rtl/led_share_sched.sv
// led_share_sched: time-slices the four board status LEDs among NUM_REQ agents.
// Requesters are granted in round-robin order for DWELL_CYCLES each, with
// GAP_CYCLES of blank LEDs between different owners. With no requester the
// LEDs show a heartbeat taken from the top four bits of a free-running counter.
//
// Ports:
//   clk25   - system clock (25 MHz)
//   rst     - synchronous reset, active-high
//   req     - per-agent level-sensitive LED request
//   pattern - per-agent 4-bit LED pattern, agent i at [4i+3:4i], sampled live
//   blink   - per-agent blink enable (gates the pattern with cntr[BLINK_BIT])
//   grant   - one-hot current owner, registered
//   busy    - high whenever the scheduler is not idle
//   leds    - LED drive, registered
module led_share_sched #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 25000000,
    parameter int GAP_CYCLES   = 2500000,
    parameter int CNTR_W       = 25,
    parameter int BLINK_BIT    = 22
) (
    input  logic                 clk25,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] pattern,
    input  logic [NUM_REQ-1:0]   blink,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [3:0]           leds
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] GAP_LAST   = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_r, state_nx_s;
    logic [NUM_REQ-1:0]   grant_r, grant_nx_s;
    logic [3:0]           leds_r, leds_nx_s;
    logic [CNTR_W-1:0]    cntr_r;
    logic [31:0]          slot_cnt_r, slot_cnt_nx_s;
    logic [IDX_W-1:0]     last_owner_r, last_owner_nx_s;

    logic [IDX_W-1:0]     winner_s;
    logic [3:0]           owner_pat_s;
    logic                 owner_blink_s;
    logic                 owner_req_s;
    logic                 other_req_s;
    state_t               ho_state_s;
    logic [NUM_REQ-1:0]   ho_grant_s;
    logic [IDX_W-1:0]     ho_last_s;
    logic                 leave_s;

    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [IDX_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin winner: scan downward so the nearest requester after last_owner wins.
    always_comb begin
        logic [IDX_W-1:0] cand_v;
        winner_s = last_owner_r;
        cand_v   = last_owner_r;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_v = IDX_W'((int'(last_owner_r) + k) % NUM_REQ);
            if (req[cand_v]) begin
                winner_s = cand_v;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Select the current owner's pattern, blink enable and request bit.
    always_comb begin
        owner_pat_s   = 4'd0;
        owner_blink_s = 1'b0;
        owner_req_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == last_owner_r) begin
                owner_pat_s   = pattern[4*i +: 4];
                owner_blink_s = blink[i];
                owner_req_s   = req[i];
            end else begin
                owner_pat_s = owner_pat_s;
            end
        end
    end

    assign other_req_s = |(req & ~onehot_f(last_owner_r));

    // Hand-off target used whenever ownership is re-arbitrated (IDLE, end of GAP, or zero-gap exit).
    always_comb begin
        if (|req) begin
            ho_state_s = ST_SHOW;
            ho_grant_s = onehot_f(winner_s);
            ho_last_s  = winner_s;
        end else begin
            ho_state_s = ST_IDLE;
            ho_grant_s = {NUM_REQ{1'b0}};
            ho_last_s  = last_owner_r;
        end
    end

    // Next-state, next-grant and next-LED logic.
    always_comb begin
        state_nx_s      = state_r;
        grant_nx_s      = grant_r;
        leds_nx_s       = leds_r;
        slot_cnt_nx_s   = slot_cnt_r;
        last_owner_nx_s = last_owner_r;
        leave_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                leds_nx_s       = cntr_r[CNTR_W-1 -: 4];
                slot_cnt_nx_s   = 32'd0;
                state_nx_s      = ho_state_s;
                grant_nx_s      = ho_grant_s;
                last_owner_nx_s = ho_last_s;
            end
            ST_SHOW: begin
                leds_nx_s     = owner_pat_s & {4{~owner_blink_s | cntr_r[BLINK_BIT]}};
                slot_cnt_nx_s = slot_cnt_r + 32'd1;
                // A dropped owner request always wins over dwell expiry.
                if (!owner_req_s) begin
                    leave_s = 1'b1;
                end else if (slot_cnt_r == DWELL_LAST) begin
                    if (other_req_s) begin
                        leave_s = 1'b1;
                    end else begin
                        slot_cnt_nx_s = 32'd0;
                    end
                end else begin
                    leave_s = 1'b0;
                end
                if (leave_s) begin
                    slot_cnt_nx_s = 32'd0;
                    if (GAP_CYCLES == 0) begin
                        state_nx_s      = ho_state_s;
                        grant_nx_s      = ho_grant_s;
                        last_owner_nx_s = ho_last_s;
                    end else begin
                        state_nx_s = ST_GAP;
                        grant_nx_s = {NUM_REQ{1'b0}};
                    end
                end else begin
                    state_nx_s = ST_SHOW;
                end
            end
            ST_GAP: begin
                grant_nx_s    = {NUM_REQ{1'b0}};
                leds_nx_s     = 4'd0;
                slot_cnt_nx_s = slot_cnt_r + 32'd1;
                if (slot_cnt_r == GAP_LAST) begin
                    slot_cnt_nx_s   = 32'd0;
                    state_nx_s      = ho_state_s;
                    grant_nx_s      = ho_grant_s;
                    last_owner_nx_s = ho_last_s;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                grant_nx_s    = {NUM_REQ{1'b0}};
                leds_nx_s     = 4'd0;
                slot_cnt_nx_s = 32'd0;
            end
        endcase
    end

    // State, grant, LED and counter registers; reset overrides everything.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= {NUM_REQ{1'b0}};
            leds_r       <= 4'd0;
            cntr_r       <= {CNTR_W{1'b0}};
            slot_cnt_r   <= 32'd0;
            last_owner_r <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_r      <= state_nx_s;
            grant_r      <= grant_nx_s;
            leds_r       <= leds_nx_s;
            cntr_r       <= cntr_r + {{(CNTR_W-1){1'b0}}, 1'b1};
            slot_cnt_r   <= slot_cnt_nx_s;
            last_owner_r <= last_owner_nx_s;
        end
    end

    assign grant = grant_r;
    assign leds  = leds_r;
    assign busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_led_share_sched.sv
// Self-checking bench for led_share_sched: a slot-level reference model
// predicts grant/busy/leds every cycle, plus hand-computed literal checks.
module tb_led_share_sched;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int GP = 2;
    localparam int CW = 8;
    localparam int BB = 2;

    logic         clk25 = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [15:0]  pattern;
    logic [3:0]   blink;
    logic [3:0]   grant;
    logic         busy;
    logic [3:0]   leds;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Reference model: phase 0=idle 1=showing 2=gap, owner index, elapsed cycles in phase.
    int         m_phase;
    int         m_owner;
    int         m_elapsed;
    int         m_hb;
    logic [3:0] m_leds;
    int         old_elapsed;
    logic [3:0] own_pat;

    logic [3:0] g_hist [1:20];
    logic [3:0] l_hist [1:20];

    always #20 clk25 = ~clk25;

    led_share_sched #(
        .NUM_REQ(NR), .DWELL_CYCLES(DW), .GAP_CYCLES(GP), .CNTR_W(CW), .BLINK_BIT(BB)
    ) dut (
        .clk25(clk25), .rst(rst), .req(req), .pattern(pattern),
        .blink(blink), .grant(grant), .busy(busy), .leds(leds)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return last;
    endfunction

    // New owner if anyone asks, otherwise go idle.
    task automatic handoff();
        if (req != 4'd0) begin
            m_owner   = rr_pick(req, m_owner);
            m_phase   = 1;
            m_elapsed = 0;
        end else begin
            m_phase   = 0;
            m_elapsed = 0;
        end
    endtask

    // Model advances on each clock edge from the inputs held stable since the last falling edge.
    always @(posedge clk25) begin
        if (rst) begin
            m_phase = 0; m_owner = NR - 1; m_elapsed = 0; m_hb = 0; m_leds = 4'd0;
        end else begin
            own_pat = pattern[4*m_owner +: 4];
            if (m_phase == 0)
                m_leds = 4'((m_hb / 16) % 16);
            else if (m_phase == 1)
                m_leds = (blink[m_owner] && ((m_hb / 4) % 2 == 0)) ? 4'd0 : own_pat;
            else
                m_leds = 4'd0;
            m_hb = (m_hb + 1) % 256;
            old_elapsed = m_elapsed;
            m_elapsed = m_elapsed + 1;
            if (m_phase == 0) begin
                handoff();
            end else if (m_phase == 1) begin
                if (!req[m_owner] || (old_elapsed == DW - 1 && (req & ~(4'd1 << m_owner)) != 4'd0)) begin
                    m_phase = 2; m_elapsed = 0;
                end else if (old_elapsed == DW - 1) begin
                    m_elapsed = 0;
                end
            end else begin
                if (old_elapsed == GP - 1) handoff();
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset has been applied.
    always @(negedge clk25) begin
        if (check_en) begin
            check("grant", {28'd0, grant}, (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
            check("busy", {31'd0, busy}, (m_phase != 0) ? 32'd1 : 32'd0);
            check("leds", {28'd0, leds}, {28'd0, m_leds});
        end
    end

    initial begin
        rst = 1'b1; req = 4'd0; pattern = 16'd0; blink = 4'd0;
        @(posedge clk25); #1 check_en = 1'b1;
        repeat (2) @(posedge clk25);
        @(negedge clk25);
        check("rst_leds", {28'd0, leds}, 32'd0);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        // Heartbeat: leds take cntr[7:4] one edge late, so 0x1 appears after the 17th edge.
        repeat (16) @(posedge clk25);
        @(negedge clk25);
        check("hb_16", {28'd0, leds}, 32'd0);
        @(posedge clk25); @(negedge clk25);
        check("hb_17", {28'd0, leds}, 32'd1);

        // Two requesters share the LEDs with a gap between owners.
        req = 4'b0101; pattern = 16'h0C03;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk25); @(negedge clk25);
            g_hist[i] = grant; l_hist[i] = leds;
        end
        for (int i = 1; i <= 8; i++) check("rr_slot0", {28'd0, g_hist[i]}, 32'd1);
        check("rr_gap_a", {28'd0, g_hist[9]}, 32'd0);
        check("rr_gap_b", {28'd0, g_hist[10]}, 32'd0);
        for (int i = 11; i <= 18; i++) check("rr_slot2", {28'd0, g_hist[i]}, 32'd4);
        check("rr_gap_c", {28'd0, g_hist[19]}, 32'd0);
        check("led_p0", {28'd0, l_hist[2]}, 32'h3);
        check("led_gap", {28'd0, l_hist[10]}, 32'h0);
        check("led_p2", {28'd0, l_hist[12]}, 32'hC);

        // Reset pulse, then a sole requester keeps the LEDs across dwell expiries.
        rst = 1'b1; req = 4'b0010; pattern = 16'h0C53;
        @(posedge clk25); @(negedge clk25);
        check("pulse_grant", {28'd0, grant}, 32'd0);
        check("pulse_leds", {28'd0, leds}, 32'd0);
        rst = 1'b0;
        @(posedge clk25); @(negedge clk25);
        check("sole_first", {28'd0, grant}, 32'd2);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk25); @(negedge clk25);
            check("sole_grant", {28'd0, grant}, 32'd2);
            check("sole_leds", {28'd0, leds}, 32'd5);
        end
        // Owner drops: blank gap, then idle.
        req = 4'b0000;
        @(posedge clk25); @(negedge clk25);
        check("drop_grant", {28'd0, grant}, 32'd0);
        check("drop_busy1", {31'd0, busy}, 32'd1);
        @(posedge clk25); @(negedge clk25);
        check("drop_busy2", {31'd0, busy}, 32'd1);
        @(posedge clk25); @(negedge clk25);
        check("drop_idle", {31'd0, busy}, 32'd0);

        // Randomised traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk25);
            if ($urandom_range(0, 11) == 0) req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) pattern = 16'($urandom);
            if ($urandom_range(0, 31) == 0) blink = 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk25);
        rst = 1'b0;
        @(negedge clk25);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
